weight_fold_ram_ctrl: RTL and testbench
=======================================

// Module: weight_fold_ram_ctrl
// PURPOSE
//  Sequencer/arbiter for the 4096x14 two-port weight-fold SRAM (CLK-shared W/R ports).
//  Owns both RAM ports: host-side LOAD streams weights into the write port; the fold
//  engine's SWEEP reads all weights in address order with per-cycle pause; optional
//  host READBACK shares the read port. Sits between the register bus and the fold datapath.
// PARAMETERS
//  ADDR_W   12    RAM address width; depth = 2**ADDR_W
//  DATA_W   14    weight width
//  RD_LAT   2     RAM read latency in CLK cycles (R_ADDR sample -> R_DATA valid, output reg used)
// PORTS
//  CLK          in   1       single clock (RAM and controller)
//  RESET        in   1       asynchronous, active-high reset
//  load_start   in   1       pulse: begin LOAD at address 0
//  load_data    in   DATA_W  weight word
//  load_valid   in   1       load_data valid
//  load_ready   out  1       word accepted when load_valid & load_ready
//  load_done    out  1       1-cycle pulse after word 2**ADDR_W-1 written
//  sweep_start  in   1       pulse: begin SWEEP at address 0
//  sweep_hold   in   1       pause address issue while high
//  sweep_valid  out  1       sweep_weight/sweep_addr valid
//  sweep_weight out  DATA_W  weight read
//  sweep_addr   out  ADDR_W  address of sweep_weight
//  sweep_last   out  1       with sweep_valid on final address
//  busy         out  1       state != IDLE or read pipeline non-empty
//  err_collide  out  1       1-cycle pulse: start request rejected
//  ram_w_addr   out  ADDR_W  / ram_w_data out DATA_W / ram_w_en out 1  -> RAM write port
//  ram_r_addr   out  ADDR_W  -> RAM read port;  ram_r_data in DATA_W <- RAM read data
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; pointers 0; read pipeline flushed. RESET mid-LOAD/SWEEP
//   aborts immediately; no load_done/sweep_last emitted; RAM contents undefined.
//  FSM IDLE->LOAD on load_start; IDLE->SWEEP on sweep_start; both same cycle: LOAD wins,
//   err_collide=1. load_start/sweep_start while not IDLE: ignored, err_collide=1.
//  LOAD: load_ready=1. Each accepted word: ram_w_en=1, ram_w_addr=wptr, ram_w_data=load_data
//   (combinational pass-through, same cycle); wptr++. Acceptance at wptr=max -> load_done
//   next cycle, wptr wraps to 0, ->IDLE. Outside LOAD ram_w_en=0, load_ready=0.
//  SWEEP: each cycle with sweep_hold=0, issue ram_r_addr=rptr, rptr++; issue at max -> IDLE
//   after that cycle. sweep_hold=1: no issue, rptr held; in-flight reads still complete.
//  Read pipeline: RD_LAT-deep shift of {issue, addr, last}; sweep_valid/addr/last emerge
//   RD_LAT cycles after issue, sweep_weight=ram_r_data that cycle. No backpressure downstream.
//  busy stays 1 until pipeline drained, so new start accepted only after last sweep_valid.
//  Address arithmetic modulo 2**ADDR_W; exactly 2**ADDR_W words per LOAD/SWEEP.
// CONFIGURATION
//  WEIGHT_FOLD_READBACK_EN defined: extra ports rb_req in 1, rb_addr in ADDR_W,
//   rb_data out DATA_W, rb_valid out 1. IDLE only (else err_collide): rb_req issues one read
//   via ram_r_addr, rb_valid pulses RD_LAT cycles later with rb_data; new rb_req accepted
//   after rb_valid. rb_req same cycle as load/sweep_start: start wins, err_collide=1.
//  Not defined: ports absent, read port driven by SWEEP only, ram_r_addr=0 otherwise.
// STRUCTURE
//  Package weight_fold_pkg: ADDR_W/DATA_W/RD_LAT defaults, typedef state_t {IDLE,LOAD,
//   SWEEP,RDBK}, typedef rd_tag_t {issue,addr,last,is_rb}.
//  Sub-module wfold_rd_pipe: RD_LAT-deep tag shift register with async reset; controller
//   holds FSM and pointers.
// TESTING
//  Full LOAD of w[a]=a^14'h155 with load_valid gaps, then SWEEP -> 4096 sweep_valid, data
//   matches, sweep_last only at addr 4095, load_done exactly once.
//  SWEEP with sweep_hold high cycles 10..19 -> no gap in addr order, exactly 10 missing
//   valid cycles, output RD_LAT=2 after each issue.
//  sweep_start+load_start same cycle in IDLE -> LOAD entered, err_collide 1 cycle.
//  sweep_start during LOAD at wptr=100 -> ignored, err_collide, LOAD completes unchanged.
//  RESET asserted at rptr=2000 -> outputs 0 next edge, no sweep_last; fresh SWEEP restarts at 0.
//  WEIGHT_FOLD_READBACK_EN: rb_req addr 12'h7FF after LOAD -> rb_valid 2 cycles later,
//   rb_data=w[2047]; rb_req during SWEEP -> err_collide, no rb_valid.

Source files
------------

// File: rtl/weight_fold_ram_ctrl_pkg.sv
// Shared defaults, FSM state encoding and read-pipeline tag for the weight-fold RAM controller.
package weight_fold_pkg;

  localparam int          ADDR_W = 12;
  localparam int          DATA_W = 14;
  localparam int unsigned RD_LAT = 2;

  typedef enum logic [1:0] {IDLE, LOAD, SWEEP, RDBK} state_t;

  typedef struct packed {
    logic              issue;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              is_rb;
  } rd_tag_t;

endpackage

// File: rtl/weight_fold_ram_ctrl_if.sv
// Host/fold-engine handshake bundle of the weight-fold RAM controller.
// Readback signals exist only when WEIGHT_FOLD_READBACK_EN is defined.
interface weight_fold_ram_ctrl_if #(
  parameter int ADDR_W = weight_fold_pkg::ADDR_W,
  parameter int DATA_W = weight_fold_pkg::DATA_W
);
  logic              load_start;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              load_ready;
  logic              load_done;
  logic              sweep_start;
  logic              sweep_hold;
  logic              sweep_valid;
  logic [DATA_W-1:0] sweep_weight;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_last;
  logic              busy;
  logic              err_collide;
`ifdef WEIGHT_FOLD_READBACK_EN
  logic              rb_req;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_data;
  logic              rb_valid;
`endif

  modport master (
    output load_start, load_data, load_valid, sweep_start, sweep_hold,
    input  load_ready, load_done, sweep_valid, sweep_weight, sweep_addr, sweep_last,
           busy, err_collide
`ifdef WEIGHT_FOLD_READBACK_EN
    , output rb_req, rb_addr
    , input  rb_data, rb_valid
`endif
  );

  modport slave (
    input  load_start, load_data, load_valid, sweep_start, sweep_hold,
    output load_ready, load_done, sweep_valid, sweep_weight, sweep_addr, sweep_last,
           busy, err_collide
`ifdef WEIGHT_FOLD_READBACK_EN
    , input  rb_req, rb_addr
    , output rb_data, rb_valid
`endif
  );

endinterface

// File: rtl/weight_fold_ram_ctrl_rd_pipe.sv
// Fixed-latency tag shift register tracking reads in flight through the RAM read port.
module wfold_rd_pipe #(
  parameter int unsigned RD_LAT = weight_fold_pkg::RD_LAT
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  weight_fold_pkg::rd_tag_t tag_in,
  output weight_fold_pkg::rd_tag_t tag_out,
  output logic                    busy
);
  import weight_fold_pkg::*;

  rd_tag_t stage [RD_LAT];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < RD_LAT; i++) busy = busy | stage[i].issue;
  end

  assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/weight_fold_ram_ctrl.sv
// Sequencer/arbiter owning both ports of the weight-fold SRAM: LOAD, SWEEP and optional
// host readback (WEIGHT_FOLD_READBACK_EN).
module weight_fold_ram_ctrl #(
  parameter int          ADDR_W = weight_fold_pkg::ADDR_W,
  parameter int          DATA_W = weight_fold_pkg::DATA_W,
  parameter int unsigned RD_LAT = weight_fold_pkg::RD_LAT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  weight_fold_ram_ctrl_if.slave host,
  output logic [ADDR_W-1:0]     ram_w_addr,
  output logic [DATA_W-1:0]     ram_w_data,
  output logic                  ram_w_en,
  output logic [ADDR_W-1:0]     ram_r_addr,
  input  logic [DATA_W-1:0]     ram_r_data
);
  import weight_fold_pkg::*;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wptr, rptr;
  logic              accept_w, issue_sw, issue_rb, last_issue;
  logic              err_nx, done_nx, err_q, done_q;
  logic              any_req, pipe_busy;
  logic              rb_req_i;
  logic [ADDR_W-1:0] rb_addr_i;
  rd_tag_t           tag_in, tag_out;

`ifdef WEIGHT_FOLD_READBACK_EN
  assign rb_req_i  = host.rb_req;
  assign rb_addr_i = host.rb_addr;
`else
  assign rb_req_i  = 1'b0;
  assign rb_addr_i = '0;
`endif

  assign any_req = host.load_start | host.sweep_start | rb_req_i;

  always_comb begin
    state_nx = state;
    accept_w = 1'b0;
    issue_sw = 1'b0;
    issue_rb = 1'b0;
    err_nx   = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        // Starts wait for the read pipeline to drain so sweeps never overlap.
        if (pipe_busy) begin
          err_nx = any_req;
        end else if (host.load_start) begin
          state_nx = LOAD;
          err_nx   = host.sweep_start | rb_req_i;
        end else if (host.sweep_start) begin
          state_nx = SWEEP;
          err_nx   = rb_req_i;
        end else if (rb_req_i) begin
          state_nx = RDBK;
          issue_rb = 1'b1;
        end
      end
      LOAD: begin
        err_nx   = any_req;
        accept_w = host.load_valid;
        if (accept_w && wptr == '1) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      SWEEP: begin
        err_nx   = any_req;
        issue_sw = ~host.sweep_hold;
        if (issue_sw && rptr == '1) state_nx = IDLE;
      end
      RDBK: begin
        err_nx = any_req;
        if (tag_out.issue && tag_out.is_rb) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      wptr   <= '0;
      rptr   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
      if (state == IDLE && state_nx == LOAD) wptr <= '0;
      else if (accept_w)                     wptr <= wptr + 1'b1;
      if (state == IDLE && state_nx == SWEEP) rptr <= '0;
      else if (issue_sw)                      rptr <= rptr + 1'b1;
    end
  end

  assign last_issue = issue_sw && (rptr == '1);
  assign ram_r_addr = issue_sw ? rptr : (issue_rb ? rb_addr_i : '0);
  assign tag_in     = '{issue: issue_sw | issue_rb, addr: ram_r_addr,
                        last: last_issue, is_rb: issue_rb};

  wfold_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .CLK    (CLK),
    .RESET  (RESET),
    .tag_in (tag_in),
    .tag_out(tag_out),
    .busy   (pipe_busy)
  );

  assign ram_w_en   = accept_w;
  assign ram_w_addr = accept_w ? wptr : '0;
  assign ram_w_data = accept_w ? host.load_data : '0;

  assign host.load_ready   = (state == LOAD);
  assign host.load_done    = done_q;
  assign host.err_collide  = err_q;
  assign host.busy         = (state != IDLE) | pipe_busy;
  assign host.sweep_valid  = tag_out.issue & ~tag_out.is_rb;
  assign host.sweep_addr   = host.sweep_valid ? tag_out.addr : '0;
  assign host.sweep_last   = host.sweep_valid & tag_out.last;
  assign host.sweep_weight = host.sweep_valid ? ram_r_data : '0;
`ifdef WEIGHT_FOLD_READBACK_EN
  assign host.rb_valid = tag_out.issue & tag_out.is_rb;
  assign host.rb_data  = host.rb_valid ? ram_r_data : '0;
`endif

endmodule

// File: tb/tb_weight_fold_ram_ctrl.sv
// Directed bench for weight_fold_ram_ctrl with a behavioural 2-cycle-latency RAM.
module tb_weight_fold_ram_ctrl;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 14;
  localparam int N      = 4096;
  localparam int RD_LAT = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  weight_fold_ram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [ADDR_W-1:0] ram_w_addr, ram_r_addr;
  logic [DATA_W-1:0] ram_w_data, ram_r_data;
  logic              ram_w_en;
  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] rd1, rd2;

  always @(posedge CLK) begin
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
    rd1 <= mem[ram_r_addr];
    rd2 <= rd1;
  end
  assign ram_r_data = rd2;

  weight_fold_ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .host      (bus),
    .ram_w_addr(ram_w_addr),
    .ram_w_data(ram_w_data),
    .ram_w_en  (ram_w_en),
    .ram_r_addr(ram_r_addr),
    .ram_r_data(ram_r_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [DATA_W-1:0] wv(input int a);
    logic [DATA_W-1:0] t;
    t = DATA_W'(a);
    return t ^ 14'h155;
  endfunction

  // Address issued in sweep cycle j (first SWEEP cycle is 0), or -1 for none.
  function automatic int issue_at(input int j, input int lo, input int hi);
    int hl;
    if (j < 0) return -1;
    if (j >= lo && j <= hi) return -1;
    hl = (hi >= lo) ? hi - lo + 1 : 0;
    if (hl > 0 && j > hi) j = j - hl;
    return (j < N) ? j : -1;
  endfunction

  task automatic test_reset;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_bad++; $display("FAIL reset_load_ready: got %b want 0", bus.load_ready); end
    n_cmp++; if (bus.load_done !== 1'b0) begin n_bad++; $display("FAIL reset_load_done: got %b want 0", bus.load_done); end
    n_cmp++; if (bus.sweep_valid !== 1'b0) begin n_bad++; $display("FAIL reset_sweep_valid: got %b want 0", bus.sweep_valid); end
    n_cmp++; if (bus.sweep_last !== 1'b0) begin n_bad++; $display("FAIL reset_sweep_last: got %b want 0", bus.sweep_last); end
    n_cmp++; if (bus.err_collide !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err_collide); end
    n_cmp++; if (ram_w_en !== 1'b0) begin n_bad++; $display("FAIL reset_w_en: got %b want 0", ram_w_en); end
    n_cmp++; if (ram_r_addr !== '0) begin n_bad++; $display("FAIL reset_r_addr: got %h want 0", ram_r_addr); end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_load(input bit both);
    int acc = 0;
    int cyc = 0;
    bit exp_err;
    bit poked = 0;
    logic [ADDR_W-1:0] ea;
    @(negedge CLK);
    bus.load_start = 1'b1; bus.sweep_start = both;
    #1;
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_bad++; $display("FAIL load_idle_ready: got %b want 0", bus.load_ready); end
    exp_err = both;
    @(negedge CLK);
    bus.load_start = 1'b0; bus.sweep_start = 1'b0;
    while (acc < N && cyc < 3 * N) begin
      bus.load_valid  = (cyc % 7) != 3;
      bus.load_data   = wv(acc);
      bus.sweep_start = (acc == 100) && !poked;
      #1;
      ea = ADDR_W'(acc);
      n_cmp++; if (bus.load_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready: got %b want 1 at word %0d", bus.load_ready, acc); end
      n_cmp++; if (bus.err_collide !== exp_err) begin n_bad++; $display("FAIL load_err: got %b want %b at word %0d", bus.err_collide, exp_err, acc); end
      n_cmp++; if (bus.load_done !== 1'b0) begin n_bad++; $display("FAIL load_done_early: got %b want 0 at word %0d", bus.load_done, acc); end
      n_cmp++; if (ram_w_en !== bus.load_valid) begin n_bad++; $display("FAIL load_w_en: got %b want %b at word %0d", ram_w_en, bus.load_valid, acc); end
      if (bus.load_valid) begin
        n_cmp++; if (ram_w_addr !== ea) begin n_bad++; $display("FAIL load_w_addr: got %h want %h", ram_w_addr, ea); end
        n_cmp++; if (ram_w_data !== wv(acc)) begin n_bad++; $display("FAIL load_w_data: got %h want %h", ram_w_data, wv(acc)); end
      end
      exp_err = bus.sweep_start;
      if (bus.sweep_start) poked = 1;
      if (bus.load_valid) acc++;
      cyc++;
      @(negedge CLK);
      bus.sweep_start = 1'b0;
    end
    bus.load_valid = 1'b0;
    #1;
    n_cmp++; if (acc !== N) begin n_bad++; $display("FAIL load_timeout: got %0d words want %0d", acc, N); end
    n_cmp++; if (bus.load_done !== 1'b1) begin n_bad++; $display("FAIL load_done: got %b want 1", bus.load_done); end
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_bad++; $display("FAIL load_ready_after: got %b want 0", bus.load_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL load_busy_after: got %b want 0", bus.busy); end
    @(negedge CLK);
    #1;
    n_cmp++; if (bus.load_done !== 1'b0) begin n_bad++; $display("FAIL load_done_pulse: got %b want 0", bus.load_done); end
    n_cmp++; if (ram_w_en !== 1'b0) begin n_bad++; $display("FAIL load_w_en_idle: got %b want 0", ram_w_en); end
  endtask

  task automatic test_sweep(input int lo, input int hi, input int abort_at);
    int hl = (hi >= lo) ? hi - lo + 1 : 0;
    int total = N + hl + RD_LAT;
    int nvalid = 0;
    int nlast = 0;
    int e, ia;
    logic [ADDR_W-1:0] ea;
    @(negedge CLK);
    bus.sweep_start = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL sweep_idle_busy: got %b want 0", bus.busy); end
    @(negedge CLK);
    bus.sweep_start = 1'b0;
    for (int k = 0; k <= total; k++) begin
      bus.sweep_hold = (k >= lo) && (k <= hi);
      if (k == abort_at) begin
        RESET = 1'b1;
        #1;
        n_cmp++; if (bus.sweep_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", bus.sweep_valid); end
        n_cmp++; if (bus.sweep_addr !== '0) begin n_bad++; $display("FAIL abort_addr: got %h want 0", bus.sweep_addr); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        n_cmp++; if (ram_r_addr !== '0) begin n_bad++; $display("FAIL abort_r_addr: got %h want 0", ram_r_addr); end
        @(negedge CLK);
        RESET = 1'b0;
        bus.sweep_hold = 1'b0;
        repeat (3) begin
          #1;
          n_cmp++; if (bus.sweep_valid !== 1'b0) begin n_bad++; $display("FAIL abort_after_valid: got %b want 0", bus.sweep_valid); end
          n_cmp++; if (bus.sweep_last !== 1'b0) begin n_bad++; $display("FAIL abort_after_last: got %b want 0", bus.sweep_last); end
          n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_after_busy: got %b want 0", bus.busy); end
          @(negedge CLK);
        end
        return;
      end
      #1;
      e  = issue_at(k - RD_LAT, lo, hi);
      ia = issue_at(k, lo, hi);
      n_cmp++; if (bus.sweep_valid !== (e >= 0)) begin n_bad++; $display("FAIL sweep_valid: got %b want %b at cycle %0d", bus.sweep_valid, (e >= 0), k); end
      if (e >= 0) begin
        ea = ADDR_W'(e);
        n_cmp++; if (bus.sweep_addr !== ea) begin n_bad++; $display("FAIL sweep_addr: got %h want %h at cycle %0d", bus.sweep_addr, ea, k); end
        n_cmp++; if (bus.sweep_weight !== wv(e)) begin n_bad++; $display("FAIL sweep_weight: got %h want %h at addr %0d", bus.sweep_weight, wv(e), e); end
        n_cmp++; if (bus.sweep_last !== (e == N - 1)) begin n_bad++; $display("FAIL sweep_last: got %b want %b at addr %0d", bus.sweep_last, (e == N - 1), e); end
      end else begin
        n_cmp++; if (bus.sweep_last !== 1'b0) begin n_bad++; $display("FAIL sweep_last_idle: got %b want 0 at cycle %0d", bus.sweep_last, k); end
      end
      ea = (ia >= 0) ? ADDR_W'(ia) : '0;
      n_cmp++; if (ram_r_addr !== ea) begin n_bad++; $display("FAIL sweep_r_addr: got %h want %h at cycle %0d", ram_r_addr, ea, k); end
      n_cmp++; if (bus.busy !== (k < total)) begin n_bad++; $display("FAIL sweep_busy: got %b want %b at cycle %0d", bus.busy, (k < total), k); end
      if (bus.sweep_valid) nvalid++;
      if (bus.sweep_last) nlast++;
      @(negedge CLK);
    end
    bus.sweep_hold = 1'b0;
    n_cmp++; if (nvalid !== N) begin n_bad++; $display("FAIL sweep_count: got %0d want %0d", nvalid, N); end
    n_cmp++; if (nlast !== 1) begin n_bad++; $display("FAIL sweep_last_count: got %0d want 1", nlast); end
  endtask

`ifdef WEIGHT_FOLD_READBACK_EN
  task automatic test_readback;
    @(negedge CLK);
    bus.rb_req = 1'b1; bus.rb_addr = 12'h7FF;
    #1;
    n_cmp++; if (ram_r_addr !== 12'h7FF) begin n_bad++; $display("FAIL rb_r_addr: got %h want 7ff", ram_r_addr); end
    n_cmp++; if (bus.rb_valid !== 1'b0) begin n_bad++; $display("FAIL rb_valid_c0: got %b want 0", bus.rb_valid); end
    @(negedge CLK);
    bus.rb_req = 1'b0;
    #1;
    n_cmp++; if (bus.rb_valid !== 1'b0) begin n_bad++; $display("FAIL rb_valid_c1: got %b want 0", bus.rb_valid); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rb_busy: got %b want 1", bus.busy); end
    @(negedge CLK);
    #1;
    n_cmp++; if (bus.rb_valid !== 1'b1) begin n_bad++; $display("FAIL rb_valid_c2: got %b want 1", bus.rb_valid); end
    n_cmp++; if (bus.rb_data !== wv(2047)) begin n_bad++; $display("FAIL rb_data: got %h want %h", bus.rb_data, wv(2047)); end
    @(negedge CLK);
    #1;
    n_cmp++; if (bus.rb_valid !== 1'b0) begin n_bad++; $display("FAIL rb_valid_c3: got %b want 0", bus.rb_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rb_busy_after: got %b want 0", bus.busy); end
    @(negedge CLK);
    bus.sweep_start = 1'b1;
    @(negedge CLK);
    bus.sweep_start = 1'b0;
    repeat (5) @(negedge CLK);
    bus.rb_req = 1'b1; bus.rb_addr = 12'h010;
    @(negedge CLK);
    bus.rb_req = 1'b0;
    #1;
    n_cmp++; if (bus.err_collide !== 1'b1) begin n_bad++; $display("FAIL rb_sweep_err: got %b want 1", bus.err_collide); end
    repeat (4) begin
      n_cmp++; if (bus.rb_valid !== 1'b0) begin n_bad++; $display("FAIL rb_sweep_valid: got %b want 0", bus.rb_valid); end
      @(negedge CLK);
      #1;
    end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask
`endif

  initial begin
    bus.load_start = 1'b0; bus.load_data = '0; bus.load_valid = 1'b0;
    bus.sweep_start = 1'b0; bus.sweep_hold = 1'b0;
`ifdef WEIGHT_FOLD_READBACK_EN
    bus.rb_req = 1'b0; bus.rb_addr = '0;
`endif
    test_reset;
    test_load(1'b1);
    test_sweep(1, 0, -1);
    test_sweep(10, 19, -1);
    test_sweep(1, 0, 2000);
    test_sweep(1, 0, -1);
`ifdef WEIGHT_FOLD_READBACK_EN
    test_readback;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
